// File: rtl/mem_access_pkg.sv
// Shared types, funct3 constants and lane helpers for the memory-stage access controller.
package mem_access_pkg;

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam int unsigned RW_STORE_BIT = 3;

    // Unused encodings fall through to a full-word access.
    function automatic size_e access_size(logic [2:0] funct3);
        size_e sz;
        case (funct3)
            F3_LB, F3_LBU: sz = SzByte;
            F3_LH, F3_LHU: sz = SzHalf;
            default:       sz = SzWord;
        endcase
        return sz;
    endfunction

    function automatic logic [3:0] byte_enable(logic [2:0] funct3, logic [1:0] addr_lo);
        logic [3:0] be;
        case (access_size(funct3))
            SzByte:  be = 4'b0001 << addr_lo;
            SzHalf:  be = 4'b0011 << {addr_lo[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(logic [2:0] funct3, logic [31:0] rs2);
        logic [31:0] data;
        case (access_size(funct3))
            SzByte:  data = {4{rs2[7:0]}};
            SzHalf:  data = {2{rs2[15:0]}};
            default: data = rs2;
        endcase
        return data;
    endfunction

    function automatic logic is_misaligned(logic [2:0] funct3, logic [1:0] addr_lo);
        logic mis;
        case (access_size(funct3))
            SzHalf:  mis = addr_lo[0];
            SzWord:  mis = |addr_lo;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/halfword lane of a read word and sign- or zero-extends it.
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] read_word_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = read_word_i[7:0];
        unique case (addr_lo_i)
            2'd0: byte_lane = read_word_i[7:0];
            2'd1: byte_lane = read_word_i[15:8];
            2'd2: byte_lane = read_word_i[23:16];
            2'd3: byte_lane = read_word_i[31:24];
        endcase

        half_lane = addr_lo_i[1] ? read_word_i[31:16] : read_word_i[15:0];

        case (funct3_i)
            F3_LB:   load_data_o = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   load_data_o = {{16{half_lane[15]}}, half_lane};
            F3_LBU:  load_data_o = {24'b0, byte_lane};
            F3_LHU:  load_data_o = {16'b0, half_lane};
            default: load_data_o = read_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues one byte-enabled request per instruction and stalls
// the pipeline until it completes. Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses.
module mem_access_unit
    import mem_access_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] IN_ALU_RESULT,
    input  logic [31:0] IN_DATA2,
    input  logic        IN_DATAMEMSEL,
    input  logic [3:0]  IN_READ_WRITE,
    input  logic        IN_HOLD,
    input  logic        MEM_BUSYWAIT,
    input  logic [31:0] MEM_READDATA,
    output logic [31:0] MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    output logic [3:0]  MEM_BYTE_EN,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic        BUSYWAIT,
    output logic [31:0] OUT_LOAD_DATA
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        OUT_MISALIGNED
`endif
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] load_q, load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  addr_lo_q, addr_lo_d;

    logic [2:0]  in_funct3;
    logic        in_store;
    logic [31:0] fmt_data;
    logic        trap_hit;

    assign in_funct3 = IN_READ_WRITE[2:0];
    assign in_store  = IN_READ_WRITE[RW_STORE_BIT];

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    assign trap_hit       = is_misaligned(in_funct3, IN_ALU_RESULT[1:0]);
    assign OUT_MISALIGNED = misaligned_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end
`else
    assign trap_hit = 1'b0;
`endif

    // Lane info is kept from issue time since MEM_ADDRESS carries no low bits.
    load_formatter u_load_formatter (
        .read_word_i (MEM_READDATA),
        .addr_lo_i   (addr_lo_q),
        .funct3_i    (funct3_q),
        .load_data_o (fmt_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        read_d    = read_q;
        write_d   = write_q;
        load_d    = load_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        BUSYWAIT  = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned_d = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (IN_DATAMEMSEL) begin
                    BUSYWAIT = 1'b1;
                    if (trap_hit) begin
                        state_d = StDone;
`ifdef MEM_MISALIGN_TRAP_EN
                        misaligned_d = 1'b1;
`endif
                    end else begin
                        addr_d    = {IN_ALU_RESULT[31:2], 2'b00};
                        wdata_d   = store_lanes(in_funct3, IN_DATA2);
                        be_d      = byte_enable(in_funct3, IN_ALU_RESULT[1:0]);
                        read_d    = ~in_store;
                        write_d   = in_store;
                        funct3_d  = in_funct3;
                        addr_lo_d = IN_ALU_RESULT[1:0];
                        state_d   = StAccess;
                    end
                end
            end
            StAccess: begin
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (read_q) begin
                        load_d = fmt_data;
                    end
                    state_d = StDone;
                end
            end
            // Holding here until the pipeline moves keeps one request per instruction.
            StDone: begin
                if (!IN_HOLD) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            load_q    <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            read_q    <= read_d;
            write_q   <= write_d;
            load_q    <= load_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign MEM_BYTE_EN   = be_q;
    assign MEM_READ      = read_q;
    assign MEM_WRITE     = write_q;
    assign OUT_LOAD_DATA = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model plus per-cycle output checks.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] IN_ALU_RESULT;
    logic [31:0] IN_DATA2;
    logic        IN_DATAMEMSEL;
    logic [3:0]  IN_READ_WRITE;
    logic        IN_HOLD;
    logic        MEM_BUSYWAIT;
    logic [31:0] MEM_READDATA;
    logic [31:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [3:0]  MEM_BYTE_EN;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic        BUSYWAIT;
    logic [31:0] OUT_LOAD_DATA;
    logic        OUT_MISALIGNED;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
    assign OUT_MISALIGNED = 1'b0;
`endif

    always #5 CLK = ~CLK;

    mem_access_unit u_dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN_ALU_RESULT (IN_ALU_RESULT),
        .IN_DATA2      (IN_DATA2),
        .IN_DATAMEMSEL (IN_DATAMEMSEL),
        .IN_READ_WRITE (IN_READ_WRITE),
        .IN_HOLD       (IN_HOLD),
        .MEM_BUSYWAIT  (MEM_BUSYWAIT),
        .MEM_READDATA  (MEM_READDATA),
        .MEM_ADDRESS   (MEM_ADDRESS),
        .MEM_WRITEDATA (MEM_WRITEDATA),
        .MEM_BYTE_EN   (MEM_BYTE_EN),
        .MEM_READ      (MEM_READ),
        .MEM_WRITE     (MEM_WRITE),
        .BUSYWAIT      (BUSYWAIT),
        .OUT_LOAD_DATA (OUT_LOAD_DATA)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .OUT_MISALIGNED(OUT_MISALIGNED)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs for the current cycle, set by the stimulus before each tick.
    bit          e_busy, e_rd, e_wr, e_mis, req_chk;
    logic [31:0] e_addr, e_wd, model_load;
    logic [3:0]  e_be;

    // Observations gathered by tick().
    int          bw_total = 0, burst_total = 0, mis_total = 0;
    bit          prev_strobe = 1'b0;
    logic [31:0] last_addr, last_wd;
    logic [3:0]  last_be;
    logic        last_wr;
    logic [31:0] s_addr, s_wd, s_load;
    logic [3:0]  s_be;
    logic        s_busy, s_rd, s_wr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] lo);
        int s = size_of(f3);
        int l = int'(lo);
        if (s == 4) return 4'hF;
        if (s == 1) return 4'(1 << l);
        return 4'(3 << ((l / 2) * 2));
    endfunction

    function automatic logic [31:0] m_wd(input logic [2:0] f3, input logic [31:0] rs2);
        int s = size_of(f3);
        if (s == 1) return {4{rs2[7:0]}};
        if (s == 2) return {2{rs2[15:0]}};
        return rs2;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
        int          s = size_of(f3);
        int          l = int'(lo);
        logic [31:0] v;
        if (s == 4) return w;
        v = (s == 1) ? (w >> (8 * l)) : (w >> (16 * (l / 2)));
        if (s == 1) return f3[2] ? {24'b0, v[7:0]} : {{24{v[7]}}, v[7:0]};
        return f3[2] ? {16'b0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    endfunction

    function automatic bit m_mis(input logic [2:0] f3, input logic [1:0] lo);
        int s = size_of(f3);
        if (s == 2) return lo[0];
        if (s == 4) return lo != 2'b00;
        return 1'b0;
    endfunction

    // One clock cycle: compare on the falling edge, return just after the next rising edge.
    task automatic tick();
        @(negedge CLK);
        chk("BUSYWAIT", 32'(BUSYWAIT), 32'(e_busy));
        chk("MEM_READ", 32'(MEM_READ), 32'(e_rd));
        chk("MEM_WRITE", 32'(MEM_WRITE), 32'(e_wr));
        chk("OUT_LOAD_DATA", OUT_LOAD_DATA, model_load);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("OUT_MISALIGNED", 32'(OUT_MISALIGNED), 32'(e_mis));
`endif
        if (req_chk) begin
            chk("MEM_ADDRESS", MEM_ADDRESS, e_addr);
            chk("MEM_BYTE_EN", 32'(MEM_BYTE_EN), 32'(e_be));
            chk("MEM_WRITEDATA", MEM_WRITEDATA, e_wd);
        end
        if (BUSYWAIT) bw_total++;
        if (OUT_MISALIGNED) mis_total++;
        if ((MEM_READ || MEM_WRITE) && !prev_strobe) burst_total++;
        if (MEM_READ || MEM_WRITE) begin
            last_addr = MEM_ADDRESS;
            last_be   = MEM_BYTE_EN;
            last_wd   = MEM_WRITEDATA;
            last_wr   = MEM_WRITE;
        end
        prev_strobe = MEM_READ || MEM_WRITE;
        s_addr = MEM_ADDRESS;
        s_wd   = MEM_WRITEDATA;
        s_be   = MEM_BYTE_EN;
        s_rd   = MEM_READ;
        s_wr   = MEM_WRITE;
        s_busy = BUSYWAIT;
        s_load = OUT_LOAD_DATA;
        @(posedge CLK);
        #1;
    endtask

    // One instruction presented to the memory stage, from IDLE back to IDLE.
    task automatic op(input bit memsel, input bit store, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                      input int waits, input int hold, output int bw, output int bursts);
        int bw0;
        int b0;
        bit mis;
        bw0 = bw_total;
        b0  = burst_total;
        mis = TrapEn && memsel && m_mis(f3, addr[1:0]);

        IN_DATAMEMSEL = memsel;
        IN_READ_WRITE = {store, f3};
        IN_ALU_RESULT = addr;
        IN_DATA2      = rs2;
        IN_HOLD       = 1'b0;
        MEM_BUSYWAIT  = 1'($urandom_range(0, 1));
        MEM_READDATA  = $urandom;
        e_busy  = memsel;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
        e_mis   = 1'b0;
        req_chk = 1'b0;
        tick();

        if (memsel) begin
            if (!mis) begin
                for (int k = 0; k <= waits; k++) begin
                    MEM_BUSYWAIT = (k < waits);
                    MEM_READDATA = (k < waits) ? $urandom : rdata;
                    e_busy  = 1'b1;
                    e_rd    = !store;
                    e_wr    = store;
                    e_addr  = {addr[31:2], 2'b00};
                    e_be    = m_be(f3, addr[1:0]);
                    e_wd    = m_wd(f3, rs2);
                    req_chk = 1'b1;
                    tick();
                end
                if (!store) model_load = m_load(rdata, addr[1:0], f3);
            end
            e_busy  = 1'b0;
            e_rd    = 1'b0;
            e_wr    = 1'b0;
            req_chk = 1'b0;
            for (int h = 0; h <= hold; h++) begin
                IN_HOLD      = (h < hold);
                MEM_BUSYWAIT = 1'($urandom_range(0, 1));
                e_mis        = mis && (h == 0);
                tick();
            end
            IN_HOLD = 1'b0;
            e_mis   = 1'b0;
        end

        bw     = bw_total - bw0;
        bursts = burst_total - b0;
        chk("busy_cycles", 32'(bw), memsel ? (mis ? 32'd1 : 32'(waits + 2)) : 32'd0);
        chk("req_bursts", 32'(bursts), (memsel && !mis) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int bw, bu, mis0;
        bit st;
        logic [2:0] f3;

        RESET = 1'b1;
        IN_ALU_RESULT = '0;
        IN_DATA2 = '0;
        IN_DATAMEMSEL = 1'b0;
        IN_READ_WRITE = '0;
        IN_HOLD = 1'b0;
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = '0;
        e_busy = 1'b0; e_rd = 1'b0; e_wr = 1'b0; e_mis = 1'b0; req_chk = 1'b0;
        e_addr = '0; e_wd = '0; e_be = '0; model_load = '0;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        tick();
        chk("rst_addr", s_addr, 32'h0);
        chk("rst_wdata", s_wd, 32'h0);
        chk("rst_be", 32'(s_be), 32'h0);
        chk("rst_strobes", 32'({s_rd, s_wr}), 32'h0);
        chk("rst_load", s_load, 32'h0);
        chk("rst_busywait", 32'(s_busy), 32'h0);

        // LW 0x100, zero-wait
        op(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, bw, bu);
        chk("lw_addr", last_addr, 32'h100);
        chk("lw_be", 32'(last_be), 32'hF);
        chk("lw_data", OUT_LOAD_DATA, 32'hDEADBEEF);
        chk("lw_busy", 32'(bw), 32'd2);

        // LB / LBU at 0x103
        op(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0, bw, bu);
        chk("lb_data", OUT_LOAD_DATA, 32'hFFFFFF80);
        chk("lb_be", 32'(last_be), 32'h8);
        op(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, 0, bw, bu);
        chk("lbu_data", OUT_LOAD_DATA, 32'h00000080);

        // SH at 0x202
        op(1'b1, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 0, 0, bw, bu);
        chk("sh_write", 32'(last_wr), 32'h1);
        chk("sh_addr", last_addr, 32'h200);
        chk("sh_be", 32'(last_be), 32'hC);
        chk("sh_wdata", last_wd, 32'hABCDABCD);
        chk("sh_load_kept", OUT_LOAD_DATA, 32'h00000080);

        // Non-memory instruction between ops
        op(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 32'h0, 0, 0, bw, bu);

        // LW with 4 wait cycles, then 2 held DONE cycles
        op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'h13572468, 4, 2, bw, bu);
        chk("lw_wait_busy", 32'(bw), 32'd6);
        chk("lw_wait_bursts", 32'(bu), 32'd1);
        chk("lw_wait_data", OUT_LOAD_DATA, 32'h13572468);

        // Reset in the middle of ACCESS
        IN_DATAMEMSEL = 1'b1;
        IN_READ_WRITE = 4'b0010;
        IN_ALU_RESULT = 32'h300;
        IN_DATA2      = 32'h0BADF00D;
        MEM_BUSYWAIT  = 1'b1;
        e_busy = 1'b1; e_rd = 1'b0; req_chk = 1'b0;
        tick();
        e_rd = 1'b1; e_addr = 32'h300; e_be = 4'hF; e_wd = 32'h0BADF00D; req_chk = 1'b1;
        tick();
        RESET = 1'b1;
        IN_DATAMEMSEL = 1'b0;
        MEM_BUSYWAIT  = 1'b0;
        MEM_READDATA  = 32'h5555AAAA;
        tick();
        RESET = 1'b0;
        model_load = '0;
        e_busy = 1'b0; e_rd = 1'b0; req_chk = 1'b0;
        tick();
        chk("midrst_strobes", 32'({s_rd, s_wr}), 32'h0);
        chk("midrst_be", 32'(s_be), 32'h0);
        chk("midrst_addr", s_addr, 32'h0);
        chk("midrst_load", s_load, 32'h0);
        chk("midrst_busywait", 32'(s_busy), 32'h0);

        // LW at 0x101: trapped when enabled, otherwise forced aligned
        mis0 = mis_total;
        op(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, bw, bu);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("mis_pulse_cycles", 32'(mis_total - mis0), 32'd1);
        chk("mis_bursts", 32'(bu), 32'd0);
        chk("mis_load_kept", OUT_LOAD_DATA, 32'h0);
`else
        chk("unaligned_addr", last_addr, 32'h100);
        chk("unaligned_data", OUT_LOAD_DATA, 32'hCAFEF00D);
`endif

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            op(($urandom_range(0, 9) < 7), st, f3, $urandom, $urandom, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), bw, bu);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
